// File: rtl/useq_if.sv
// Sequencer-facing bundle: decoder selectors, current microword sequencing
// fields, memory handshake, restart pulse, and the sequencer's outputs.
interface useq_if #(
  parameter int UAW = 6
);
  logic [2:0]     ib;
  logic [2:0]     sb;
  logic [2:0]     mop;
  logic [UAW-1:0] mjmp;
  logic           cond;
  logic           mem_req;
  logic           mem_rdy;
  logic           start;
  logic [UAW-1:0] upc;
  logic           ir_ld;
  logic           halted;

  modport master (
    output ib, sb, mop, mjmp, cond, mem_req, mem_rdy, start,
    input  upc, ir_ld, halted
  );

  modport slave (
    input  ib, sb, mop, mjmp, cond, mem_req, mem_rdy, start,
    output upc, ir_ld, halted
  );
endinterface

// File: rtl/useq.sv
// Microprogram sequencer: computes the next micro-address from the current
// microword's sequencing op, with a one-deep return register and a HALT state.
//
// state | meaning
// RUN   | executing microwords; upc advances per mop unless memory stalls
// HALT  | halt instruction dispatched; everything frozen until start
module useq #(
  parameter int UAW = 6
) (
  input  logic   clk,
  input  logic   reset,
  useq_if.slave  bus
);
  localparam logic [2:0] OP_NEXT     = 3'b000;
  localparam logic [2:0] OP_DISPATCH = 3'b001;
  localparam logic [2:0] OP_FETCH    = 3'b010;
  localparam logic [2:0] OP_CALL     = 3'b011;
  localparam logic [2:0] OP_RET      = 3'b100;
  localparam logic [2:0] OP_JMP      = 3'b101;
  localparam logic [2:0] OP_JMPC     = 3'b110;

  localparam int             OW  = UAW - 3;
  localparam logic [UAW-1:0] ONE = {{(UAW-1){1'b0}}, 1'b1};

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t         state, state_nx;
  logic [UAW-1:0] upc, upc_nx;
  logic [UAW-1:0] ret, ret_nx;
  logic [UAW-1:0] inc;
  logic           stall;
  logic           ir_ld;

  // Routines are aligned blocks; the selector becomes the high address bits.
  function automatic logic [UAW-1:0] entry(input logic [2:0] sel);
    return {sel, {OW{1'b0}}};
  endfunction

  assign stall = bus.mem_req & ~bus.mem_rdy;
  assign inc   = upc + ONE;

  // Next-address, return-register and state selection; IR strobe on unstalled FETCH.
  always_comb begin
    state_nx = state;
    upc_nx   = upc;
    ret_nx   = ret;
    ir_ld    = 1'b0;
    if (state == HALT) begin
      if (bus.start) begin
        upc_nx   = '0;
        state_nx = RUN;
      end
    end else if (!stall) begin
      case (bus.mop)
        OP_NEXT:     upc_nx = inc;
        OP_DISPATCH: begin
          // ib=sb=0 encodes the halt instruction; upc stays on the dispatch word.
          if (bus.ib == 3'd0 && bus.sb == 3'd0) state_nx = HALT;
          else                                  upc_nx   = entry(bus.ib);
        end
        OP_FETCH: begin
          ir_ld  = 1'b1;
          upc_nx = '0;
        end
        OP_CALL: begin
          ret_nx = inc;
          upc_nx = entry(bus.sb);
        end
        OP_RET:  upc_nx = ret;
        OP_JMP:  upc_nx = bus.mjmp;
        OP_JMPC: upc_nx = bus.cond ? bus.mjmp : inc;
        default: upc_nx = bus.cond ? inc : bus.mjmp;
      endcase
    end
  end

  // State, micro-PC and return register update; reset aborts any stall or halt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      upc   <= '0;
      ret   <= '0;
    end else begin
      state <= state_nx;
      upc   <= upc_nx;
      ret   <= ret_nx;
    end
  end

  assign bus.upc    = upc;
  assign bus.ir_ld  = ir_ld;
  assign bus.halted = (state == HALT);
endmodule

// File: tb/tb_useq.sv
// Self-checking bench for useq: directed scenarios plus a randomized run
// against a reference model; expected micro-addresses go through a queue.
module tb_useq;
  localparam int UAW = 6;
  localparam logic [2:0] NEXT = 3'd0, DISP = 3'd1, FETCH = 3'd2, CALL = 3'd3;
  localparam logic [2:0] RET = 3'd4, JMP = 3'd5, JMPC = 3'd6, JMPNC = 3'd7;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [UAW-1:0] exp_q[$];

  always #5 clk = ~clk;

  useq_if #(.UAW(UAW)) bus ();
  useq #(.UAW(UAW)) dut (.clk(clk), .reset(reset), .bus(bus));

  task automatic apply(input logic [2:0] op, input logic [UAW-1:0] jmp,
                       input logic [2:0] i, input logic [2:0] s, input logic c,
                       input logic rq, input logic rd, input logic st);
    bus.mop = op; bus.mjmp = jmp; bus.ib = i; bus.sb = s; bus.cond = c;
    bus.mem_req = rq; bus.mem_rdy = rd; bus.start = st;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    apply(NEXT, '0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (bus.upc !== 6'h00) begin errors++; $display("FAIL reset_upc got=%h exp=00", bus.upc); end
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b exp=0", bus.halted); end
    checks++; if (bus.ir_ld !== 1'b0) begin errors++; $display("FAIL reset_irld got=%b exp=0", bus.ir_ld); end
    bus.mop = FETCH;
    #1;
    checks++; if (bus.ir_ld !== 1'b1) begin errors++; $display("FAIL reset_irld_fetch got=%b exp=1", bus.ir_ld); end
    bus.mop = NEXT;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_next();
    logic [UAW-1:0] e;
    for (int i = 1; i <= 3; i++) begin
      apply(NEXT, '0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(UAW'(i));
      cyc();
      e = exp_q.pop_front();
      checks++; if (bus.upc !== e) begin errors++; $display("FAIL next%0d upc got=%h exp=%h", i, bus.upc, e); end
    end
  endtask

  task automatic test_wrap_jump();
    logic [2:0]     op[6];
    logic [UAW-1:0] jmp[6];
    logic           c[6];
    logic [UAW-1:0] ex[6];
    logic [UAW-1:0] e;
    op  = '{JMP, NEXT, JMPC, JMPC, JMPNC, JMPNC};
    jmp = '{6'h3F, 6'h00, 6'h15, 6'h2A, 6'h2A, 6'h2A};
    c   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    ex  = '{6'h3F, 6'h00, 6'h15, 6'h16, 6'h17, 6'h2A};
    for (int i = 0; i < 6; i++) begin
      apply(op[i], jmp[i], 3'd0, 3'd0, c[i], 1'b0, 1'b0, 1'b0);
      exp_q.push_back(ex[i]);
      cyc();
      e = exp_q.pop_front();
      checks++; if (bus.upc !== e) begin errors++; $display("FAIL wrap_jump%0d upc got=%h exp=%h", i, bus.upc, e); end
    end
  endtask

  task automatic test_dispatch();
    logic [2:0]     ib[4];
    logic [2:0]     sb[4];
    logic [UAW-1:0] ex[4];
    logic [UAW-1:0] e;
    ib = '{3'd6, 3'd1, 3'd7, 3'd0};
    sb = '{3'd5, 3'd2, 3'd0, 3'd3};
    ex = '{6'h30, 6'h08, 6'h38, 6'h00};
    for (int i = 0; i < 4; i++) begin
      apply(DISP, 6'h3F, ib[i], sb[i], 1'b0, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(ex[i]);
      cyc();
      e = exp_q.pop_front();
      checks++; if (bus.upc !== e) begin errors++; $display("FAIL dispatch%0d upc got=%h exp=%h", i, bus.upc, e); end
      checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL dispatch%0d halted got=%b exp=0", i, bus.halted); end
    end
  endtask

  task automatic test_subroutine();
    logic [2:0]     op[8];
    logic [UAW-1:0] jmp[8];
    logic [2:0]     sb[8];
    logic [UAW-1:0] ex[8];
    logic [UAW-1:0] e;
    op  = '{JMP, CALL, NEXT, NEXT, RET, CALL, CALL, RET};
    jmp = '{6'h09, 6'h3E, 6'h3E, 6'h3E, 6'h3E, 6'h3E, 6'h3E, 6'h3E};
    sb  = '{3'd0, 3'd5, 3'd0, 3'd0, 3'd0, 3'd3, 3'd2, 3'd6};
    ex  = '{6'h09, 6'h28, 6'h29, 6'h2A, 6'h0A, 6'h18, 6'h10, 6'h19};
    for (int i = 0; i < 8; i++) begin
      apply(op[i], jmp[i], 3'd7, sb[i], 1'b1, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(ex[i]);
      cyc();
      e = exp_q.pop_front();
      checks++; if (bus.upc !== e) begin errors++; $display("FAIL subroutine%0d upc got=%h exp=%h", i, bus.upc, e); end
    end
  endtask

  task automatic test_stall();
    logic [UAW-1:0] e;
    for (int k = 0; k < 3; k++) begin
      apply(FETCH, 6'h3F, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      #1;
      checks++; if (bus.ir_ld !== 1'b0) begin errors++; $display("FAIL stall%0d irld got=%b exp=0", k, bus.ir_ld); end
      exp_q.push_back(6'h19);
      cyc();
      e = exp_q.pop_front();
      checks++; if (bus.upc !== e) begin errors++; $display("FAIL stall%0d upc got=%h exp=%h", k, bus.upc, e); end
    end
    apply(FETCH, 6'h3F, 3'd0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    #1;
    checks++; if (bus.ir_ld !== 1'b1) begin errors++; $display("FAIL stall_done irld got=%b exp=1", bus.ir_ld); end
    exp_q.push_back(6'h00);
    cyc();
    e = exp_q.pop_front();
    checks++; if (bus.upc !== e) begin errors++; $display("FAIL stall_done upc got=%h exp=%h", bus.upc, e); end
    // Stalled dispatch must use the selector present when it completes.
    apply(DISP, '0, 3'd2, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(6'h00);
    cyc();
    e = exp_q.pop_front();
    checks++; if (bus.upc !== e) begin errors++; $display("FAIL stall_disp_hold upc got=%h exp=%h", bus.upc, e); end
    apply(DISP, '0, 3'd4, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0);
    exp_q.push_back(6'h20);
    cyc();
    e = exp_q.pop_front();
    checks++; if (bus.upc !== e) begin errors++; $display("FAIL stall_disp_done upc got=%h exp=%h", bus.upc, e); end
  endtask

  task automatic test_halt();
    logic [UAW-1:0] e;
    apply(NEXT, '0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(6'h21);
    cyc();
    apply(DISP, '0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(6'h21);
    cyc();
    e = exp_q.pop_front();
    e = exp_q.pop_front();
    checks++; if (bus.upc !== e) begin errors++; $display("FAIL halt_enter upc got=%h exp=%h", bus.upc, e); end
    checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL halt_enter halted got=%b exp=1", bus.halted); end
    for (int k = 0; k < 5; k++) begin
      apply(3'($urandom_range(0, 7)), UAW'($urandom), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      if (k == 0) bus.mop = FETCH;
      #1;
      checks++; if (bus.ir_ld !== 1'b0) begin errors++; $display("FAIL halt_idle%0d irld got=%b exp=0", k, bus.ir_ld); end
      exp_q.push_back(6'h21);
      cyc();
      e = exp_q.pop_front();
      checks++; if (bus.upc !== e) begin errors++; $display("FAIL halt_idle%0d upc got=%h exp=%h", k, bus.upc, e); end
      checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL halt_idle%0d halted got=%b exp=1", k, bus.halted); end
    end
    apply(JMP, 6'h2B, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    exp_q.push_back(6'h00);
    cyc();
    e = exp_q.pop_front();
    checks++; if (bus.upc !== e) begin errors++; $display("FAIL halt_start upc got=%h exp=%h", bus.upc, e); end
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL halt_start halted got=%b exp=0", bus.halted); end
    // Return register survives HALT; start in RUN has no effect.
    apply(RET, '0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(6'h19);
    cyc();
    e = exp_q.pop_front();
    checks++; if (bus.upc !== e) begin errors++; $display("FAIL halt_ret upc got=%h exp=%h", bus.upc, e); end
    apply(NEXT, '0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_q.push_back(6'h1A);
    cyc();
    e = exp_q.pop_front();
    checks++; if (bus.upc !== e) begin errors++; $display("FAIL start_in_run upc got=%h exp=%h", bus.upc, e); end
    apply(JMP, 6'h05, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    apply(DISP, '0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL halt_again halted got=%b exp=1", bus.halted); end
    bus.mop = NEXT;
    reset = 1'b1;
    #1;
    checks++; if (bus.upc !== 6'h00) begin errors++; $display("FAIL halt_reset upc got=%h exp=00", bus.upc); end
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL halt_reset halted got=%b exp=0", bus.halted); end
    @(negedge clk);
    reset = 1'b0;
    apply(NEXT, '0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    apply(NEXT, '0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    apply(RET, '0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(6'h00);
    cyc();
    e = exp_q.pop_front();
    checks++; if (bus.upc !== e) begin errors++; $display("FAIL reset_ret upc got=%h exp=%h", bus.upc, e); end
  endtask

  task automatic test_back_to_back();
    logic [UAW-1:0] m_upc, m_ret, m_inc, e;
    logic           m_halt, st, exp_ir;
    logic [2:0]     op, ib, sb;
    logic [UAW-1:0] jmp;
    logic           c, rq, rd;
    m_upc = 6'h00; m_ret = 6'h00; m_halt = 1'b0;
    for (int k = 0; k < 80; k++) begin
      op  = 3'($urandom_range(0, 7));
      jmp = UAW'($urandom);
      ib  = 3'($urandom_range(0, 7));
      sb  = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) begin ib = 3'd0; sb = 3'd0; end
      c   = 1'($urandom_range(0, 1));
      rq  = ($urandom_range(0, 2) == 0);
      rd  = 1'($urandom_range(0, 1));
      st  = ($urandom_range(0, 3) == 0);
      apply(op, jmp, ib, sb, c, rq, rd, st);
      exp_ir = !m_halt && (op == FETCH) && !(rq && !rd);
      m_inc  = m_upc + 6'h01;
      if (m_halt) begin
        if (st) begin m_upc = 6'h00; m_halt = 1'b0; end
      end else if (!(rq && !rd)) begin
        case (op)
          NEXT:  m_upc = m_inc;
          DISP:  if (ib == 3'd0 && sb == 3'd0) m_halt = 1'b1; else m_upc = {ib, 3'b000};
          FETCH: m_upc = 6'h00;
          CALL:  begin m_ret = m_inc; m_upc = {sb, 3'b000}; end
          RET:   m_upc = m_ret;
          JMP:   m_upc = jmp;
          JMPC:  m_upc = c ? jmp : m_inc;
          default: m_upc = c ? m_inc : jmp;
        endcase
      end
      #1;
      checks++; if (bus.ir_ld !== exp_ir) begin errors++; $display("FAIL b2b%0d irld got=%b exp=%b", k, bus.ir_ld, exp_ir); end
      exp_q.push_back(m_upc);
      cyc();
      e = exp_q.pop_front();
      checks++; if (bus.upc !== e) begin errors++; $display("FAIL b2b%0d upc got=%h exp=%h", k, bus.upc, e); end
      checks++; if (bus.halted !== m_halt) begin errors++; $display("FAIL b2b%0d halted got=%b exp=%b", k, bus.halted, m_halt); end
    end
  endtask

  initial begin
    test_reset();
    test_next();
    test_wrap_jump();
    test_dispatch();
    test_subroutine();
    test_stall();
    test_halt();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
